// File: rtl/tns_pkg.sv
// Constants and codeword helper for the 3-wire base-7 TSV codec.
package tns_pkg;

    localparam int unsigned TNS_RADIX  = 7;
    localparam int unsigned TNS_GROUPS = 3;
    localparam int unsigned TNS_DATA_W = 9;
    localparam int unsigned TNS_MAX    = 342;

    localparam logic [2:0] TNS_CW_D0    = 3'b000;
    localparam logic [2:0] TNS_CW_D1    = 3'b001;
    localparam logic [2:0] TNS_CW_D2    = 3'b010;
    localparam logic [2:0] TNS_CW_D3    = 3'b101;
    localparam logic [2:0] TNS_CW_D4    = 3'b110;
    localparam logic [2:0] TNS_CW_D5    = 3'b111;
    localparam logic [2:0] TNS_CW_D6_LO = 3'b011;
    localparam logic [2:0] TNS_CW_D6_HI = 3'b100;

    // Digit 6 keeps b2 unchanged so the group's top wire never toggles on it.
    function automatic logic [2:0] tns_enc_digit(input logic [2:0] digit, input logic prev_b2);
        logic [2:0] cw;
        cw = TNS_CW_D0;
        case (digit)
            3'd0:    cw = TNS_CW_D0;
            3'd1:    cw = TNS_CW_D1;
            3'd2:    cw = TNS_CW_D2;
            3'd3:    cw = TNS_CW_D3;
            3'd4:    cw = TNS_CW_D4;
            3'd5:    cw = TNS_CW_D5;
            3'd6:    cw = prev_b2 ? TNS_CW_D6_HI : TNS_CW_D6_LO;
            default: cw = TNS_CW_D0;
        endcase
        return cw;
    endfunction

endpackage

// File: rtl/tns_group_dec.sv
// Stateless decode of one 3-wire group back to its base-7 digit.
module tns_group_dec
    import tns_pkg::*;
(
    input  logic [2:0] code,
    output logic [2:0] digit
);

    always_comb begin
        digit = 3'd0;
        case (code)
            TNS_CW_D0:    digit = 3'd0;
            TNS_CW_D1:    digit = 3'd1;
            TNS_CW_D2:    digit = 3'd2;
            TNS_CW_D3:    digit = 3'd3;
            TNS_CW_D4:    digit = 3'd4;
            TNS_CW_D5:    digit = 3'd5;
            TNS_CW_D6_LO: digit = 3'd6;
            TNS_CW_D6_HI: digit = 3'd6;
            default:      digit = 3'd0;
        endcase
    end

endmodule

// File: rtl/tns_codec_09.sv
// Base-7 TSV codec: registered 3-group encoder with combinational decode of the bus.
module tns_codec_09
    import tns_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic [TNS_DATA_W-1:0] data_in,
    output logic [TNS_DATA_W-1:0] tsv,
    output logic [TNS_DATA_W-1:0] data_out
);

    localparam int unsigned DATA_W  = TNS_DATA_W;
    localparam int unsigned NGROUPS = TNS_GROUPS;

    logic [DATA_W-1:0] sat_c;
    logic [2:0]        enc_dig_c [NGROUPS];
    logic [2:0]        dec_dig_c [NGROUPS];
    logic [DATA_W-1:0] tsv_d;
    logic [DATA_W-1:0] tsv_q;

    // Saturate, split into base-7 digits, and pick codewords against the current b2.
    always_comb begin
        sat_c = (data_in > DATA_W'(TNS_MAX)) ? DATA_W'(TNS_MAX) : data_in;
        enc_dig_c[0] = 3'(sat_c % DATA_W'(TNS_RADIX));
        enc_dig_c[1] = 3'((sat_c / DATA_W'(TNS_RADIX)) % DATA_W'(TNS_RADIX));
        enc_dig_c[2] = 3'(sat_c / DATA_W'(TNS_RADIX * TNS_RADIX));
        tsv_d = '0;
        for (int unsigned g = 0; g < NGROUPS; g++) begin
            tsv_d[3*g +: 3] = tns_enc_digit(enc_dig_c[g], tsv_q[3*g+2]);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tsv_q <= '0;
        end else begin
            tsv_q <= tsv_d;
        end
    end

    assign tsv = tsv_q;

    for (genvar g = 0; g < NGROUPS; g++) begin : g_dec
        tns_group_dec u_group_dec (
            .code  (tsv_q[3*g +: 3]),
            .digit (dec_dig_c[g])
        );
    end

    always_comb begin
        data_out = DATA_W'(dec_dig_c[0])
                 + DATA_W'(dec_dig_c[1]) * DATA_W'(TNS_RADIX)
                 + DATA_W'(dec_dig_c[2]) * DATA_W'(TNS_RADIX * TNS_RADIX);
    end

endmodule

// File: tb/tb_tns_codec_09.sv
// Bench for tns_codec_09: directed vector table, async reset sequence, random run vs. model.
module tb_tns_codec_09;

    logic       clock;
    logic       reset;
    logic [8:0] data_in;
    logic [8:0] tsv;
    logic [8:0] data_out;

    int total = 0;
    int bad   = 0;

    tns_codec_09 dut (
        .clock    (clock),
        .reset    (reset),
        .data_in  (data_in),
        .tsv      (tsv),
        .data_out (data_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [8:0] din;
        logic [8:0] exp_tsv;
        logic [8:0] exp_dout;
    } vec_t;

    logic [2:0] cw_tab [6] = '{3'b000, 3'b001, 3'b010, 3'b101, 3'b110, 3'b111};

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b (%0d) expected %b (%0d)", name, act, act, exp, exp);
        end
    endtask

    task automatic step(input logic [8:0] din);
        @(negedge clock);
        data_in = din;
        @(posedge clock);
        #1;
    endtask

    // Spec-level encoder: saturate, base-7 digits by arithmetic, codeword table, b2-aware digit 6.
    function automatic logic [8:0] model_enc(input int v, input logic [8:0] prev);
        int s;
        int d;
        logic [8:0] r;
        s = (v > 342) ? 342 : v;
        r = '0;
        for (int g = 0; g < 3; g++) begin
            d = s % 7;
            s = s / 7;
            if (d == 6) r[3*g +: 3] = prev[3*g+2] ? 3'b100 : 3'b011;
            else        r[3*g +: 3] = cw_tab[d];
        end
        return r;
    endfunction

    initial begin
        vec_t vecs [13];
        logic [8:0] model_tsv;
        logic [8:0] prev_tsv;
        logic [8:0] viol;
        int v;

        vecs[0]  = '{9'd6,   9'b000000011, 9'd6};
        vecs[1]  = '{9'd3,   9'b000000101, 9'd3};
        vecs[2]  = '{9'd6,   9'b000000100, 9'd6};
        vecs[3]  = '{9'd342, 9'b011011100, 9'd342};
        vecs[4]  = '{9'd0,   9'b000000000, 9'd0};
        vecs[5]  = '{9'd400, 9'b011011011, 9'd342};
        vecs[6]  = '{9'd48,  9'b000011011, 9'd48};
        vecs[7]  = '{9'd49,  9'b001000000, 9'd49};
        vecs[8]  = '{9'd300, 9'b011000011, 9'd300};
        vecs[9]  = '{9'd511, 9'b011011011, 9'd342};
        vecs[10] = '{9'd5,   9'b000000111, 9'd5};
        vecs[11] = '{9'd6,   9'b000000100, 9'd6};
        vecs[12] = '{9'd13,  9'b000001100, 9'd13};

        reset   = 1'b1;
        data_in = 9'd0;
        #12;
        check("reset_tsv", tsv, 9'd0);
        check("reset_dout", data_out, 9'd0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            step(vecs[i].din);
            check($sformatf("vec%0d_tsv", i), tsv, vecs[i].exp_tsv);
            check($sformatf("vec%0d_dout", i), data_out, vecs[i].exp_dout);
        end

        // Asynchronous reset mid-cycle, then held across an edge.
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_tsv", tsv, 9'd0);
        check("async_rst_dout", data_out, 9'd0);
        step(9'd100);
        check("rst_hold_tsv", tsv, 9'd0);
        @(negedge clock);
        reset = 1'b0;

        step(9'd342);
        check("post_rst_342_tsv", tsv, 9'b011011011);
        check("post_rst_342_dout", data_out, 9'd342);
        step(9'd0);
        check("post_rst_0_tsv", tsv, 9'd0);
        check("post_rst_0_dout", data_out, 9'd0);

        model_tsv = 9'd0;
        for (int n = 0; n < 10000; n++) begin
            v = int'($urandom_range(0, 342));
            prev_tsv = tsv;
            step(9'(v));
            model_tsv = model_enc(v, model_tsv);
            check("rand_dout", data_out, 9'(v));
            check("rand_tsv", tsv, model_tsv);
            viol = '0;
            for (int g = 0; g < 3; g++) begin
                if (tsv[3*g +: 3] == 3'b100 && !prev_tsv[3*g+2]) viol[g] = 1'b1;
                if (tsv[3*g +: 3] == 3'b011 &&  prev_tsv[3*g+2]) viol[g] = 1'b1;
            end
            check("rand_b2_rule", viol, 9'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
